// File: rtl/pipe_hazard_scoreboard.sv
// rtl/pipe_hazard_scoreboard.sv - hazard/forwarding controller for the in-order pipeline
// Tracks writers in the stages after ID; forwards the youngest match, stalls on unready results.
module pipe_hazard_scoreboard #(
  parameter int XLEN   = 64,
  parameter int NSTAGE = 3,
  parameter int MAXLAT = 8,
  parameter int LAT_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [4:0]               id_rs1,
  input  logic [4:0]               id_rs2,
  input  logic                     id_rs1_use,
  input  logic                     id_rs2_use,
  input  logic [4:0]               id_rd,
  input  logic                     id_wen,
  input  logic                     id_load,
  input  logic [LAT_W-1:0]         id_lat,
  input  logic [XLEN-1:0]          id_busa,
  input  logic [XLEN-1:0]          id_busb,
  input  logic [NSTAGE*XLEN-1:0]   stage_res,
  input  logic                     redirect,
  output logic [XLEN-1:0]          busa_o,
  output logic [XLEN-1:0]          busb_o,
  output logic [NSTAGE-1:0]        fwd_a_sel,
  output logic [NSTAGE-1:0]        fwd_b_sel,
  output logic                     stall,
  output logic                     ex_hold,
  output logic                     ex_issue
);

  logic [NSTAGE-1:0]      v_q, v_d, wen_q, wen_d, load_q, load_d;
  logic [NSTAGE-1:0][4:0] rd_q, rd_d;
  logic [LAT_W-1:0]       cnt_q, cnt_d, eff_lat;
  logic                   rdy_a, rdy_b;

  // Scan from the oldest stage down so the youngest (lowest index) match overwrites.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    busa_o    = id_busa;
    busb_o    = id_busb;
    for (int k = NSTAGE-1; k >= 0; k--) begin
      if (id_rs1_use && id_rs1 != 5'd0 && v_q[k] && wen_q[k] && rd_q[k] == id_rs1) begin
        fwd_a_sel    = '0;
        fwd_a_sel[k] = 1'b1;
        busa_o       = stage_res[k*XLEN +: XLEN];
      end
      if (id_rs2_use && id_rs2 != 5'd0 && v_q[k] && wen_q[k] && rd_q[k] == id_rs2) begin
        fwd_b_sel    = '0;
        fwd_b_sel[k] = 1'b1;
        busb_o       = stage_res[k*XLEN +: XLEN];
      end
    end
  end

  // Only the EX writer can be unready: a load, or a multi-cycle op still counting.
  assign rdy_a    = !(fwd_a_sel[0] && (load_q[0] || cnt_q != '0));
  assign rdy_b    = !(fwd_b_sel[0] && (load_q[0] || cnt_q != '0));
  assign ex_hold  = rst && (cnt_q != '0);
  assign stall    = rst && id_valid && (ex_hold || !rdy_a || !rdy_b);
  assign ex_issue = rst && id_valid && !stall && !redirect;

  always_comb begin
    if (id_lat == '0)
      eff_lat = LAT_W'(1);
    else if (id_lat > LAT_W'(MAXLAT))
      eff_lat = LAT_W'(MAXLAT);
    else
      eff_lat = id_lat;
  end

  always_comb begin
    v_d    = v_q;
    rd_d   = rd_q;
    wen_d  = wen_q;
    load_d = load_q;
    cnt_d  = cnt_q;
    for (int k = 2; k < NSTAGE; k++) begin
      v_d[k]    = v_q[k-1];
      rd_d[k]   = rd_q[k-1];
      wen_d[k]  = wen_q[k-1];
      load_d[k] = load_q[k-1];
    end
    rd_d[1]   = rd_q[0];
    wen_d[1]  = wen_q[0];
    load_d[1] = load_q[0];
    if (ex_hold) begin
      v_d[1] = 1'b0;
      cnt_d  = cnt_q - LAT_W'(1);
    end else begin
      v_d[1]    = v_q[0];
      v_d[0]    = ex_issue;
      rd_d[0]   = id_rd;
      wen_d[0]  = id_wen;
      load_d[0] = id_load;
      cnt_d     = ex_issue ? eff_lat - LAT_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q    <= '0;
      rd_q   <= '0;
      wen_q  <= '0;
      load_q <= '0;
      cnt_q  <= '0;
    end else begin
      v_q    <= v_d;
      rd_q   <= rd_d;
      wen_q  <= wen_d;
      load_q <= load_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb/tb_pipe_hazard_scoreboard.sv - directed and random checks against an in-flight list model
module tb_pipe_hazard_scoreboard;
  localparam int XLEN = 64, NSTAGE = 3, MAXLAT = 8, LAT_W = 4;

  logic clk, rst, id_valid, id_rs1_use, id_rs2_use, id_wen, id_load, redirect;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [LAT_W-1:0] id_lat;
  logic [XLEN-1:0] id_busa, id_busb, busa_o, busb_o;
  logic [NSTAGE*XLEN-1:0] stage_res;
  logic [NSTAGE-1:0] fwd_a_sel, fwd_b_sel;
  logic stall, ex_hold, ex_issue;

  pipe_hazard_scoreboard #(.XLEN(XLEN), .NSTAGE(NSTAGE), .MAXLAT(MAXLAT), .LAT_W(LAT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use), .id_rd(id_rd), .id_wen(id_wen),
    .id_load(id_load), .id_lat(id_lat), .id_busa(id_busa), .id_busb(id_busb),
    .stage_res(stage_res), .redirect(redirect), .busa_o(busa_o), .busb_o(busb_o),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .ex_hold(ex_hold),
    .ex_issue(ex_issue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each in-flight instruction: which stage it sits in and EX cycles still owed.
  typedef struct {
    logic [4:0] rd;
    logic       wen;
    logic       load;
    int         stage;
    int         rem;
  } instr_t;
  instr_t flight[$];

  int total = 0, passed = 0;
  logic m_hold, m_issue;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
  endtask

  task automatic pick(input logic use_, input logic [4:0] rs, input logic [XLEN-1:0] rf,
                      output logic [XLEN-1:0] bus, output logic [NSTAGE-1:0] sel, output logic rdy);
    int best = NSTAGE;
    int bi = -1;
    bus = rf;
    sel = '0;
    rdy = 1'b1;
    if (use_ && rs != 5'd0)
      foreach (flight[i])
        if (flight[i].wen && flight[i].rd == rs && flight[i].stage < best) begin
          best = flight[i].stage;
          bi = i;
        end
    if (bi >= 0) begin
      bus = stage_res[best*XLEN +: XLEN];
      sel[best] = 1'b1;
      if (best == 0) rdy = !flight[bi].load && flight[bi].rem == 0;
    end
  endtask

  task automatic settle();
    logic [XLEN-1:0] ea, eb;
    logic [NSTAGE-1:0] sa, sb;
    logic ra, rb, st;
    #1;
    pick(id_rs1_use, id_rs1, id_busa, ea, sa, ra);
    pick(id_rs2_use, id_rs2, id_busb, eb, sb, rb);
    m_hold = 1'b0;
    foreach (flight[i]) if (flight[i].stage == 0 && flight[i].rem > 0) m_hold = 1'b1;
    m_hold = m_hold && rst;
    st = rst && id_valid && (m_hold || !ra || !rb);
    m_issue = rst && id_valid && !st && !redirect;
    check("stall", 64'(stall), 64'(st));
    check("ex_hold", 64'(ex_hold), 64'(m_hold));
    check("ex_issue", 64'(ex_issue), 64'(m_issue));
    check("busa_o", busa_o, ea);
    check("fwd_a_sel", 64'(fwd_a_sel), 64'(sa));
    check("busb_o", busb_o, eb);
    check("fwd_b_sel", 64'(fwd_b_sel), 64'(sb));
  endtask

  task automatic tick();
    instr_t n;
    int eff;
    @(posedge clk);
    if (!rst) flight.delete();
    else begin
      foreach (flight[i]) begin
        if (m_hold && flight[i].stage == 0) flight[i].rem--;
        else flight[i].stage++;
      end
      if (m_issue) begin
        eff = (id_lat == 0) ? 1 : (int'(id_lat) > MAXLAT ? MAXLAT : int'(id_lat));
        n.rd = id_rd; n.wen = id_wen; n.load = id_load; n.stage = 0; n.rem = eff - 1;
        flight.push_back(n);
      end
      for (int i = flight.size() - 1; i >= 0; i--)
        if (flight[i].stage >= NSTAGE) flight.delete(i);
    end
    #1;
  endtask

  task automatic id_set(input logic val, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic wen, input logic ld, input logic [LAT_W-1:0] lat);
    id_valid = val; id_rs1 = rs1; id_rs1_use = u1; id_rs2 = rs2; id_rs2_use = u2;
    id_rd = rd; id_wen = wen; id_load = ld; id_lat = lat; redirect = 1'b0;
    id_busa = {$urandom, $urandom};
    id_busb = {$urandom, $urandom};
    for (int k = 0; k < NSTAGE; k++) stage_res[k*XLEN +: XLEN] = {$urandom, $urandom};
  endtask

  task automatic drain();
    for (int i = 0; i < NSTAGE + MAXLAT; i++) begin
      id_set(0, 0, 0, 0, 0, 0, 0, 0, 1);
      settle();
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    id_set(1, 5, 1, 6, 1, 5, 1, 0, 3);
    settle(); tick();
    settle();
    check("reset_stall", 64'(stall), 64'(0));
    check("reset_issue", 64'(ex_issue), 64'(0));
    check("reset_sel_a", 64'(fwd_a_sel), 64'(0));
    tick();
    rst = 1'b1;
    drain();

    // addi x5 then a reader of x5 forwards from EX
    id_set(1, 0, 0, 0, 0, 5, 1, 0, 1); settle(); tick();
    id_set(1, 5, 1, 0, 0, 9, 1, 0, 1); settle();
    check("t1_stall", 64'(stall), 64'(0));
    check("t1_sel_a", 64'(fwd_a_sel), 64'(3'b001));
    check("t1_busa", busa_o, stage_res[0 +: XLEN]);
    tick(); drain();

    // load-use stalls one cycle then forwards from M
    id_set(1, 0, 0, 0, 0, 6, 1, 1, 1); settle(); tick();
    id_set(1, 0, 0, 6, 1, 11, 1, 0, 1); settle();
    check("t2_stall", 64'(stall), 64'(1));
    tick();
    id_set(1, 0, 0, 6, 1, 11, 1, 0, 1); settle();
    check("t2_sel_b", 64'(fwd_b_sel), 64'(3'b010));
    check("t2_issue", 64'(ex_issue), 64'(1));
    check("t2_busb", busb_o, stage_res[XLEN +: XLEN]);
    tick(); drain();

    // four-cycle mul holds EX for three cycles
    id_set(1, 0, 0, 0, 0, 7, 1, 0, 4); settle(); tick();
    for (int c = 1; c <= 3; c++) begin
      id_set(1, 7, 1, 0, 0, 13, 1, 0, 1); settle();
      check("t3_hold", 64'(ex_hold), 64'(1));
      check("t3_stall", 64'(stall), 64'(1));
      tick();
    end
    id_set(1, 7, 1, 0, 0, 13, 1, 0, 1); settle();
    check("t3_hold_end", 64'(ex_hold), 64'(0));
    check("t3_sel_a", 64'(fwd_a_sel), 64'(3'b001));
    check("t3_issue", 64'(ex_issue), 64'(1));
    tick(); drain();

    // x8 in both EX and WB: youngest wins
    id_set(1, 0, 0, 0, 0, 8, 1, 0, 1); settle(); tick();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 1); settle(); tick();
    id_set(1, 0, 0, 0, 0, 8, 1, 0, 1); settle(); tick();
    id_set(1, 8, 1, 0, 0, 14, 1, 0, 1); settle();
    check("t4_sel_a", 64'(fwd_a_sel), 64'(3'b001));
    check("t4_busa", busa_o, stage_res[0 +: XLEN]);
    tick(); drain();

    // x0 writer never forwards
    id_set(1, 0, 0, 0, 0, 0, 1, 0, 1); settle(); tick();
    id_set(1, 0, 1, 0, 0, 15, 1, 0, 1); id_busa = '0; settle();
    check("t5_stall", 64'(stall), 64'(0));
    check("t5_sel_a", 64'(fwd_a_sel), 64'(0));
    check("t5_busa", busa_o, 64'(0));
    tick(); drain();

    // redirect during a load-use stall, then reset during a long op
    id_set(1, 0, 0, 0, 0, 10, 1, 1, 1); settle(); tick();
    id_set(1, 10, 1, 0, 0, 16, 1, 0, 1); redirect = 1'b1; settle();
    check("t6_issue", 64'(ex_issue), 64'(0));
    tick();
    id_set(1, 10, 1, 0, 0, 16, 1, 0, 1); settle();
    check("t6_sel_m", 64'(fwd_a_sel), 64'(3'b010));
    tick(); drain();
    id_set(1, 0, 0, 0, 0, 12, 1, 0, 6); settle(); tick();
    id_set(1, 12, 1, 0, 0, 17, 1, 0, 1); settle();
    check("t6_hold_pre", 64'(ex_hold), 64'(1));
    rst = 1'b0; settle();
    check("t6_rst_hold", 64'(ex_hold), 64'(0));
    tick();
    rst = 1'b1;
    id_set(1, 12, 1, 0, 0, 17, 1, 0, 1); settle();
    check("t6_post_hold", 64'(ex_hold), 64'(0));
    check("t6_post_sel", 64'(fwd_a_sel), 64'(0));
    tick(); drain();

    // random traffic on a small register set to provoke hazards
    for (int n = 0; n < 600; n++) begin
      id_set(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 5) == 0) ? LAT_W'($urandom_range(0, 10)) : LAT_W'(1));
      redirect = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 49) != 0);
      settle();
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
